// File: rtl/fxp_arb_pkg.sv
// Shared helpers for the float-to-fixed round-robin arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fxp_arb_pkg;

    localparam int FLT_W = 32;

    // Index width that stays at least 1 bit, so NREQ=1 still has a legal ID port.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comb_Float32toFixedPoint.sv
// IEEE-754 single precision to signed fixed point (WOI integer bits incl. sign, WOF fraction bits).
// Latency: purely combinational.
// Backpressure: none; output follows input.
// Ports: in_float (32b operand) -> out_fixed (WOI+WOF signed), out_upflow, out_downflow.
module comb_Float32toFixedPoint #(
    parameter int WOI   = 10,
    parameter int WOF   = 10,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic [31:0]        in_float,
    output logic [WOI+WOF-1:0] out_fixed,
    output logic               out_upflow,
    output logic               out_downflow
);
    localparam int W  = WOI + WOF;
    // Wide enough for the 24-bit significand shifted left by up to W places.
    localparam int MW = W + 26;
    localparam logic [MW-1:0] MAX_POS = (MW'(1) << (W - 1)) - MW'(1);
    localparam logic [MW-1:0] MAX_NEG = MW'(1) << (W - 1);

    logic              sign_f;
    logic [7:0]        exp_f;
    logic [22:0]       man_f;
    logic [MW-1:0]     mant_w;
    logic [MW-1:0]     half;
    logic [MW-1:0]     mag;
    logic signed [15:0] sh;
    logic [4:0]        rsh;
    logic              big;
    logic              ovf;

    assign sign_f = in_float[31];
    assign exp_f  = in_float[30:23];
    assign man_f  = in_float[22:0];
    assign mant_w = MW'({1'b1, man_f});

    always_comb begin
        big  = 1'b0;
        mag  = '0;
        half = '0;
        rsh  = '0;
        // Scaled value = {1,man} * 2^(exp - 150 + WOF).
        sh   = $signed({8'd0, exp_f}) - 16'sd150 + 16'(WOF);
        if (exp_f == 8'hFF) begin
            // Inf and NaN are forced to saturate towards their sign.
            big = 1'b1;
        end else if (exp_f == 8'h00) begin
            // Zero and denormals flush to zero.
            mag = '0;
        end else if (sh >= 0) begin
            if (sh > 16'(W)) begin
                big = 1'b1;
            end else begin
                mag = mant_w << sh[7:0];
            end
        end else if (sh >= -16'sd25) begin
            rsh = 5'(-sh);
            if (ROUND != 0) begin
                half = MW'(1) << (rsh - 5'd1);
            end
            mag = (mant_w + half) >> rsh;
        end
    end

    always_comb begin
        ovf          = sign_f ? (big || (mag > MAX_NEG)) : (big || (mag > MAX_POS));
        out_upflow   = ovf && !sign_f;
        out_downflow = ovf && sign_f;
        if (ovf && (ROOF != 0)) begin
            out_fixed = sign_f ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            out_fixed = sign_f ? (~mag[W-1:0] + 1'b1) : mag[W-1:0];
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, scanning upward with wrap.
// Latency: purely combinational.
// Backpressure: caller masks req when it cannot accept.
// Ports: req, ptr -> gnt (one-hot), gnt_idx, gnt_vld.
module rr_arbiter
    import fxp_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]       req,
    input  logic [idw(N)-1:0]  ptr,
    output logic [N-1:0]       gnt,
    output logic [idw(N)-1:0]  gnt_idx,
    output logic               gnt_vld
);
    localparam int IW = idw(N);

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_vld && req[idx]) begin
                gnt_vld      = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/float2fixed_rr_arbiter.sv
// Shares one float->fixed converter among NREQ producers via round-robin, registered output.
// Latency: accepted at edge N, result visible after edge N; one result per cycle.
// Backpressure: req_ready drops to 0 while the output register is full and not being consumed.
// Ports: req_valid/req_ready/req_float per requester; out_valid/out_ready/out_id/out_fixed/
//        out_upflow/out_downflow result; sticky_ovf/sticky_clr per-requester overflow status.
module float2fixed_rr_arbiter
    import fxp_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WOI   = 10,
    parameter int WOF   = 10,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic                   rstn,
    input  logic                   clk,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*32-1:0]     req_float,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [idw(NREQ)-1:0]   out_id,
    output logic [WOI+WOF-1:0]     out_fixed,
    output logic                   out_upflow,
    output logic                   out_downflow,
    output logic [NREQ-1:0]        sticky_ovf,
    input  logic [NREQ-1:0]        sticky_clr
);
    localparam int IW = idw(NREQ);
    localparam int W  = WOI + WOF;

    logic [IW-1:0]   ptr_q, ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [IW-1:0]   out_id_q, out_id_d;
    logic [W-1:0]    out_fixed_q, out_fixed_d;
    logic            out_up_q, out_up_d;
    logic            out_dn_q, out_dn_d;
    logic [NREQ-1:0] sticky_q, sticky_d;

    logic            out_free;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_vld;
    logic [31:0]     sel_float;
    logic [W-1:0]    cv_fixed;
    logic            cv_up;
    logic            cv_dn;

    // The register can take a new result if empty or being drained this cycle.
    assign out_free = !out_valid_q || out_ready;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req     (req_valid & {NREQ{out_free}}),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign sel_float = req_float[32*gnt_idx +: 32];

    comb_Float32toFixedPoint #(
        .WOI   (WOI),
        .WOF   (WOF),
        .ROOF  (ROOF),
        .ROUND (ROUND)
    ) u_conv (
        .in_float     (sel_float),
        .out_fixed    (cv_fixed),
        .out_upflow   (cv_up),
        .out_downflow (cv_dn)
    );

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_fixed_d = out_fixed_q;
        out_up_d    = out_up_q;
        out_dn_d    = out_dn_q;
        // Clear first so a same-cycle overflow set wins.
        sticky_d    = sticky_q & ~sticky_clr;
        if (gnt_vld) begin
            out_valid_d = 1'b1;
            out_id_d    = gnt_idx;
            out_fixed_d = cv_fixed;
            out_up_d    = cv_up;
            out_dn_d    = cv_dn;
            ptr_d       = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
            if (cv_up || cv_dn) begin
                sticky_d = sticky_d | gnt;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_fixed_q <= '0;
            out_up_q    <= 1'b0;
            out_dn_q    <= 1'b0;
            sticky_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_fixed_q <= out_fixed_d;
            out_up_q    <= out_up_d;
            out_dn_q    <= out_dn_d;
            sticky_q    <= sticky_d;
        end
    end

    assign req_ready    = gnt;
    assign out_valid    = out_valid_q;
    assign out_id       = out_id_q;
    assign out_fixed    = out_fixed_q;
    assign out_upflow   = out_up_q;
    assign out_downflow = out_dn_q;
    assign sticky_ovf   = sticky_q;

endmodule

// File: tb/tb_float2fixed_rr_arbiter.sv
// Bench for float2fixed_rr_arbiter with NREQ=4, WOI=10, WOF=10, saturate + round.
// Latency: n/a.
// Backpressure: exercised through out_ready.
module tb_float2fixed_rr_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 20;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_float;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_id;
    logic [W-1:0]      out_fixed;
    logic              out_upflow;
    logic              out_downflow;
    logic [NREQ-1:0]   sticky_ovf;
    logic [NREQ-1:0]   sticky_clr;

    always #5 clk = ~clk;

    float2fixed_rr_arbiter #(
        .NREQ(NREQ), .WOI(10), .WOF(10), .ROOF(1), .ROUND(1)
    ) dut (
        .rstn         (rstn),
        .clk          (clk),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_float    (req_float),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_id       (out_id),
        .out_fixed    (out_fixed),
        .out_upflow   (out_upflow),
        .out_downflow (out_downflow),
        .sticky_ovf   (sticky_ovf),
        .sticky_clr   (sticky_clr)
    );

    typedef struct {
        logic [1:0]  id;
        logic [19:0] fx;
        logic        up;
        logic        dn;
    } res_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] f;
        logic [19:0] fx;
        logic        up;
        logic        dn;
        logic [3:0]  sticky;
    } vec_t;

    res_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    logic       mdl_valid;
    logic [1:0] mdl_ptr;
    logic [3:0] mdl_sticky;
    int         issued[NREQ];
    int         consumed[NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion through real arithmetic, round half away from zero, saturate.
    task automatic ref_conv(input logic [31:0] f, output logic [19:0] fx,
                            output logic up, output logic dn);
        real   mag;
        real   rm;
        longint v;
        int    ex;
        fx = '0; up = 1'b0; dn = 1'b0;
        if (f[30:23] == 8'hFF) begin
            up = !f[31];
            dn = f[31];
        end else if (f[30:23] != 8'h00) begin
            mag = $itor({8'd0, 1'b1, f[22:0]});
            ex  = int'(f[30:23]) - 140;
            while (ex > 0) begin mag = mag * 2.0; ex--; end
            while (ex < 0) begin mag = mag / 2.0; ex++; end
            rm = $floor(mag + 0.5);
            if (!f[31] && rm > 524287.0) up = 1'b1;
            else if (f[31] && rm > 524288.0) dn = 1'b1;
            else begin
                v  = longint'(rm);
                fx = f[31] ? 20'(-v) : 20'(v);
            end
        end
        if (up) fx = 20'h7FFFF;
        if (dn) fx = 20'h80000;
    endtask

    // One clock cycle: compare DUT against the model, advance the model, step to the next negedge.
    task automatic cycle();
        logic [3:0]  g;
        int          gi;
        logic        free;
        res_t        r;
        logic [19:0] efx;
        logic        eup;
        logic        edn;
        #1;
        chk("out_valid", 32'(out_valid), 32'(mdl_valid));
        if (mdl_valid) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard: output present, 0 entries expected at %0t", $time);
            end else begin
                r = sbq[0];
                chk("sb_id", 32'(out_id), 32'(r.id));
                chk("sb_fixed", 32'(out_fixed), 32'(r.fx));
                chk("sb_upflow", 32'(out_upflow), 32'(r.up));
                chk("sb_downflow", 32'(out_downflow), 32'(r.dn));
            end
        end
        free = !mdl_valid || out_ready;
        g  = '0;
        gi = -1;
        if (free) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (int'(mdl_ptr) + k) % NREQ;
                if (gi < 0 && req_valid[idx]) begin
                    gi     = idx;
                    g[idx] = 1'b1;
                end
            end
        end
        chk("req_ready", 32'(req_ready), 32'(g));
        chk("sticky_ovf", 32'(sticky_ovf), 32'(mdl_sticky));
        if (mdl_valid && out_ready && sbq.size() > 0) begin
            r = sbq.pop_front();
            consumed[r.id]++;
        end
        mdl_sticky = mdl_sticky & ~sticky_clr;
        if (gi >= 0) begin
            ref_conv(req_float[gi*32 +: 32], efx, eup, edn);
            r.id = 2'(gi); r.fx = efx; r.up = eup; r.dn = edn;
            sbq.push_back(r);
            issued[gi]++;
            mdl_valid = 1'b1;
            mdl_ptr   = 2'((gi + 1) % NREQ);
            if (eup || edn) mdl_sticky[gi] = 1'b1;
        end else if (out_ready) begin
            mdl_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_float();
        return {1'($urandom_range(0, 1)), 8'(118 + $urandom_range(0, 20)), 23'($urandom)};
    endfunction

    task automatic model_reset();
        mdl_valid  = 1'b0;
        mdl_ptr    = '0;
        mdl_sticky = '0;
        sbq.delete();
        for (int i = 0; i < NREQ; i++) begin
            issued[i]   = 0;
            consumed[i] = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tv[6];
        logic [19:0] held_fx;
        logic [1:0]  held_id;

        tv[0] = '{2'd2, 32'hc36f0d77, 20'hC43CA, 1'b0, 1'b0, 4'b0000};
        tv[1] = '{2'd1, 32'h44696e31, 20'h7FFFF, 1'b1, 1'b0, 4'b0010};
        tv[2] = '{2'd0, 32'h00000000, 20'h00000, 1'b0, 1'b0, 4'b0010};
        tv[3] = '{2'd3, 32'h80000000, 20'h00000, 1'b0, 1'b0, 4'b0010};
        tv[4] = '{2'd2, 32'h407e7564, 20'h00FE7, 1'b0, 1'b0, 4'b0010};
        tv[5] = '{2'd3, 32'hc427f97f, 20'h80000, 1'b0, 1'b1, 4'b1010};

        rstn       = 1'b0;
        req_valid  = '0;
        req_float  = '0;
        out_ready  = 1'b1;
        sticky_clr = '0;
        model_reset();

        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_out_fixed", 32'(out_fixed), 32'd0);
        chk("rst_out_upflow", 32'(out_upflow), 32'd0);
        chk("rst_out_downflow", 32'(out_downflow), 32'd0);
        chk("rst_sticky", 32'(sticky_ovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Single-requester vectors: result visible one edge after acceptance.
        for (int i = 0; i < 6; i++) begin
            req_valid = 4'b0001 << tv[i].id;
            req_float[tv[i].id*32 +: 32] = tv[i].f;
            cycle();
            req_valid = '0;
            chk("vec_valid", 32'(out_valid), 32'd1);
            chk("vec_id", 32'(out_id), 32'(tv[i].id));
            chk("vec_fixed", 32'(out_fixed), 32'(tv[i].fx));
            chk("vec_upflow", 32'(out_upflow), 32'(tv[i].up));
            chk("vec_downflow", 32'(out_downflow), 32'(tv[i].dn));
            chk("vec_sticky", 32'(sticky_ovf), 32'(tv[i].sticky));
        end

        // Consume with no new grant: valid falls, data holds.
        cycle();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_hold_fixed", 32'(out_fixed), 32'h80000);

        // Sticky set beats same-cycle clear; plain clears afterwards.
        req_valid = 4'b0010;
        req_float[32 +: 32] = 32'h44696e31;
        sticky_clr = 4'b0010;
        cycle();
        chk("sticky_set_wins", 32'(sticky_ovf), 32'b1010);
        req_valid  = '0;
        sticky_clr = 4'b0010;
        cycle();
        chk("sticky_clr1", 32'(sticky_ovf), 32'b1000);
        sticky_clr = 4'b1000;
        cycle();
        sticky_clr = '0;
        chk("sticky_clr3", 32'(sticky_ovf), 32'b0000);

        // Fairness: last grant was requester 1, so rotation resumes at 2.
        req_valid = 4'hF;
        for (int k = 0; k < 12; k++) begin
            for (int r = 0; r < NREQ; r++) req_float[r*32 +: 32] = rnd_float();
            cycle();
            chk("rr_order", 32'(out_id), 32'((2 + k) % NREQ));
        end

        // Backpressure: output frozen, no grants, then resume at the pointer successor.
        held_fx   = out_fixed;
        held_id   = out_id;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int r = 0; r < NREQ; r++) req_float[r*32 +: 32] = rnd_float();
            cycle();
            chk("bp_hold_fixed", 32'(out_fixed), 32'(held_fx));
            chk("bp_hold_id", 32'(out_id), 32'(held_id));
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_resume_id", 32'(out_id), 32'((int'(held_id) + 1) % NREQ));
        for (int k = 0; k < 6; k++) begin
            out_ready = k[0];
            for (int r = 0; r < NREQ; r++) req_float[r*32 +: 32] = rnd_float();
            cycle();
        end
        out_ready = 1'b1;
        req_valid = '0;
        cycle();
        cycle();
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        for (int i = 0; i < NREQ; i++) begin
            chk("sb_per_id", 32'(consumed[i]), 32'(issued[i]));
        end

        // Asynchronous reset while a result is held.
        req_valid = 4'hF;
        cycle();
        cycle();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_id", 32'(out_id), 32'd0);
        chk("arst_fixed", 32'(out_fixed), 32'd0);
        chk("arst_flags", 32'({out_upflow, out_downflow}), 32'd0);
        chk("arst_sticky", 32'(sticky_ovf), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cycle();
        chk("post_rst_first_id", 32'(out_id), 32'd0);
        cycle();
        chk("post_rst_second_id", 32'(out_id), 32'd1);
        req_valid = '0;
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
